// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, pop strobe and FIFO/status outputs of the UART receive front end.
interface uart_rx_fifo_if;
    logic       rx;
    logic       rd;
    logic [7:0] drec;
    logic       avail;
    logic       full;
    logic       ferr;
    logic       ovr;
    modport master(output rx, rd, input drec, avail, full, ferr, ovr);
    modport slave(input rx, rd, output drec, avail, full, ferr, ovr);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a small first-word fall-through FIFO.
module uart_rx_fifo #(
    parameter int clk_freq   = 50000000,
    parameter int baud       = 115200,
    parameter int depth_log2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_fifo_if.slave bus
);
    localparam int div   = clk_freq / (baud * 16);
    localparam int dw    = $clog2(div);
    localparam int depth = 1 << depth_log2;
    localparam int cw    = depth_log2 + 1;

    if (div < 2) begin : g_div_check
        $error("uart_rx_fifo: clk_freq/(baud*16) must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rxs;
    logic [dw-1:0]        tcnt;
    logic                 tick;
    logic [3:0]           sc, sc_n;
    logic [2:0]           bi, bi_n;
    logic [7:0]           sh, sh_n;
    logic                 push, ferr_n;
    logic [7:0]           mem [depth];
    logic [depth_log2-1:0] rp, wp;
    logic [cw-1:0]        cnt;
    logic                 do_pop, do_push;

    assign rxs  = sync[1];
    assign tick = tcnt == dw'(div - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= 2'b11;
            tcnt  <= '0;
            state <= IDLE;
            sc    <= '0;
            bi    <= '0;
            sh    <= '0;
        end else begin
            sync  <= {sync[0], bus.rx};
            tcnt  <= tick ? '0 : tcnt + dw'(1);
            state <= state_n;
            sc    <= sc_n;
            bi    <= bi_n;
            sh    <= sh_n;
        end
    end

    // sc counts ticks within a bit; a wrap from 15 marks the next bit center
    always_comb begin
        state_n = state;
        sc_n    = sc;
        bi_n    = bi;
        sh_n    = sh;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_n = START;
                sc_n    = '0;
            end
            START: if (tick) begin
                if (sc == 4'd7) begin
                    state_n = rxs ? IDLE : DATA;
                    sc_n    = '0;
                    bi_n    = '0;
                end else begin
                    sc_n = sc + 4'd1;
                end
            end
            DATA: if (tick) begin
                sc_n = sc + 4'd1;
                if (sc == 4'd15) begin
                    sh_n[bi] = rxs;
                    bi_n     = bi + 3'd1;
                    state_n  = bi == 3'd7 ? STOP : DATA;
                end
            end
            STOP: if (tick) begin
                sc_n = sc + 4'd1;
                if (sc == 4'd15) begin
                    push    = rxs;
                    ferr_n  = !rxs;
                    state_n = rxs ? IDLE : WAIT;
                end
            end
            WAIT: if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // a pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
    assign do_pop  = bus.rd && cnt != '0;
    assign do_push = push && (!bus.full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            rp       <= '0;
            wp       <= '0;
            cnt      <= '0;
            bus.ferr <= 1'b0;
            bus.ovr  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wp] <= sh;
                wp      <= wp + depth_log2'(1);
            end
            if (do_pop) rp <= rp + depth_log2'(1);
            cnt      <= cnt + cw'(do_push) - cw'(do_pop);
            bus.ferr <= ferr_n;
            bus.ovr  <= push && !do_push;
        end
    end

    assign bus.drec  = mem[rp];
    assign bus.avail = cnt != '0;
    assign bus.full  = cnt == cw'(depth);
endmodule
